// File: rtl/muxf_tree_pkg.sv
// muxf_tree_pkg: shared limits and elaboration helpers
// for the pipelined wide-mux tree.
package muxf_tree_pkg;

  localparam int MUXF_TREE_MAX_IN    = 64;
  localparam int MUXF_TREE_MAX_WIDTH = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Register boundaries = ceil(levels / levels_per_reg).
  function automatic int lat_calc(input int num_in,
                                  input int levels_per_reg);
    int lv;
    lv = clog2(num_in);
    if (levels_per_reg < 1) return 0;
    return (lv + levels_per_reg - 1) / levels_per_reg;
  endfunction

endpackage

// File: rtl/muxf_tree_level.sv
// muxf_tree_level: one rank of 2:1 muxes, optionally
// followed by a CE/reset pipeline register.
module muxf_tree_level
  import muxf_tree_pkg::*;
#(
  parameter int              WIDTH = 1,
  parameter int              N_IN  = 2,
  parameter int              SW    = 1,
  parameter bit              REG   = 1'b1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_ce,
  input  logic                      i_v,
  input  logic [N_IN*WIDTH-1:0]     i_d,
  input  logic [SW-1:0]             i_s,
  output logic                      o_v,
  output logic [(N_IN/2)*WIDTH-1:0] o_d,
  output logic [SW-1:0]             o_s
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*WIDTH-1:0] w_d;
  logic [SW-1:0]          w_s;

  // Pair (2j, 2j+1) -> j; select bit 0 picks the odd bus.
  always_comb begin
    w_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (i_s[0])
        w_d[j*WIDTH +: WIDTH] = i_d[(2*j+1)*WIDTH +: WIDTH];
      else
        w_d[j*WIDTH +: WIDTH] = i_d[(2*j)*WIDTH +: WIDTH];
    end
  end

  // Drop the consumed bit so the next level sees its bit at [0].
  if (SW > 1) begin : g_shift
    assign w_s = {1'b0, i_s[SW-1:1]};
  end else begin : g_last
    assign w_s = '0;
  end

  if (REG) begin : g_reg
    logic [N_OUT*WIDTH-1:0] r_d;
    logic [SW-1:0]          r_s;
    logic                   r_v;

    // Data and remaining selects load on every enabled edge; valid rides along.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_d <= {N_OUT{INIT}};
        r_s <= '0;
        r_v <= 1'b0;
      end else if (i_ce) begin
        r_d <= w_d;
        r_s <= w_s;
        r_v <= i_v;
      end
    end

    assign o_d = r_d;
    assign o_s = r_s;
    assign o_v = r_v;
  end else begin : g_comb
    assign o_d = w_d;
    assign o_s = w_s;
    assign o_v = i_v;
  end

endmodule

// File: rtl/muxf_tree_pipe.sv
// muxf_tree_pipe: pipelined NUM_IN:1 wide mux tree.
// Define MUXF_TREE_LO_EN to add the LO local output.
module muxf_tree_pipe
  import muxf_tree_pkg::*;
#(
  parameter int               WIDTH          = 1,
  parameter int               NUM_IN         = 8,
  parameter int               LEVELS_PER_REG = 1,
  parameter logic [WIDTH-1:0] INIT           = '0,
  localparam int              LOG2_N         = clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CE,
  input  logic                    VI,
  input  logic [NUM_IN*WIDTH-1:0] I,
  input  logic [LOG2_N-1:0]       S,
  output logic                    VO,
  output logic [WIDTH-1:0]        O
`ifdef MUXF_TREE_LO_EN
  ,
  output logic [WIDTH-1:0]        LO
`endif
);

  if (!is_pow2(NUM_IN) || NUM_IN < 2 ||
      NUM_IN > MUXF_TREE_MAX_IN) begin : g_bad_n
    $error("muxf_tree_pipe: illegal NUM_IN=%0d", NUM_IN);
  end

  if (LEVELS_PER_REG < 1 ||
      LEVELS_PER_REG > LOG2_N) begin : g_bad_lpr
    $error("muxf_tree_pipe: illegal LEVELS_PER_REG=%0d",
           LEVELS_PER_REG);
  end

  if (WIDTH < 1 || WIDTH > MUXF_TREE_MAX_WIDTH) begin : g_bad_w
    $error("muxf_tree_pipe: illegal WIDTH=%0d", WIDTH);
  end

  for (genvar k = 0; k < LOG2_N; k++) begin : g_lvl
    localparam int NI = NUM_IN >> k;
    localparam bit RG = ((k + 1) % LEVELS_PER_REG == 0) ||
                        (k == LOG2_N - 1);

    logic [NI*WIDTH-1:0]     w_di;
    logic [LOG2_N-1:0]       w_si;
    logic                    w_vi;
    logic [(NI/2)*WIDTH-1:0] w_do;
    logic [LOG2_N-1:0]       w_so;
    logic                    w_vo;

    if (k == 0) begin : g_in
      assign w_di = I;
      assign w_si = S;
      assign w_vi = VI;
    end else begin : g_chain
      assign w_di = g_lvl[k-1].w_do;
      assign w_si = g_lvl[k-1].w_so;
      assign w_vi = g_lvl[k-1].w_vo;
    end

    muxf_tree_level #(
      .WIDTH (WIDTH),
      .N_IN  (NI),
      .SW    (LOG2_N),
      .REG   (RG),
      .INIT  (INIT)
    ) u_lvl (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_ce    (CE),
      .i_v     (w_vi),
      .i_d     (w_di),
      .i_s     (w_si),
      .o_v     (w_vo),
      .o_d     (w_do),
      .o_s     (w_so)
    );
  end

  assign O  = g_lvl[LOG2_N-1].w_do;
  assign VO = g_lvl[LOG2_N-1].w_vo;

`ifdef MUXF_TREE_LO_EN
  assign LO = g_lvl[LOG2_N-1].w_do;
`endif

endmodule

// File: tb/tb_muxf_tree_pipe.sv
// tb_muxf_tree_pipe: vector table, directed corner cases and
// random traffic against a delay-queue reference model.
module tb_muxf_tree_pipe;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic CE = 1'b1;

  logic [63:0]  I0; logic [2:0] S0; logic VI0, VO0;
  logic [7:0]   O0, LO0;
  logic [15:0]  I1; logic [0:0] S1; logic VI1, VO1;
  logic [7:0]   O1, LO1;
  logic [255:0] I2; logic [5:0] S2; logic VI2, VO2;
  logic [3:0]   O2, LO2;
  logic [63:0]  I3; logic [2:0] S3; logic VI3, VO3;
  logic [7:0]   O3, LO3;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  muxf_tree_pipe #(.WIDTH(8), .NUM_IN(8), .LEVELS_PER_REG(1),
                   .INIT(8'hA5)) u0 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .VI(VI0), .I(I0),
    .S(S0), .VO(VO0), .O(O0)
`ifdef MUXF_TREE_LO_EN
    , .LO(LO0)
`endif
  );

  muxf_tree_pipe #(.WIDTH(8), .NUM_IN(2), .LEVELS_PER_REG(1),
                   .INIT(8'h3C)) u1 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .VI(VI1), .I(I1),
    .S(S1), .VO(VO1), .O(O1)
`ifdef MUXF_TREE_LO_EN
    , .LO(LO1)
`endif
  );

  muxf_tree_pipe #(.WIDTH(4), .NUM_IN(64), .LEVELS_PER_REG(6),
                   .INIT(4'h9)) u2 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .VI(VI2), .I(I2),
    .S(S2), .VO(VO2), .O(O2)
`ifdef MUXF_TREE_LO_EN
    , .LO(LO2)
`endif
  );

  muxf_tree_pipe #(.WIDTH(8), .NUM_IN(8), .LEVELS_PER_REG(2),
                   .INIT(8'h00)) u3 (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .VI(VI3), .I(I3),
    .S(S3), .VO(VO3), .O(O3)
`ifdef MUXF_TREE_LO_EN
    , .LO(LO3)
`endif
  );

  typedef struct {
    logic [63:0] d;
    logic [2:0]  s;
    logic [7:0]  e;
  } vec_t;

  typedef struct {
    logic       v;
    logic [7:0] o;
  } ent_t;

  vec_t tbl[7];
  ent_t q0[$], q1[$], q2[$], q3[$];
  ent_t e;

  localparam logic [63:0] BUS10 = 64'h1716151413121110;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    tbl[0] = '{BUS10,                 3'd5, 8'h15};
    tbl[1] = '{64'h0001020304050607,  3'd2, 8'h05};
    tbl[2] = '{64'hFF00000000000000,  3'd7, 8'hFF};
    tbl[3] = '{64'hFF00000000000000,  3'd6, 8'h00};
    tbl[4] = '{64'hDEADBEEFCAFEF00D,  3'd3, 8'hCA};
    tbl[5] = '{64'hDEADBEEFCAFEF00D,  3'd4, 8'hEF};
    tbl[6] = '{64'hDEADBEEFCAFEF00D,  3'd0, 8'h0D};

    I0 = '0; S0 = '0; VI0 = 0;
    I1 = '0; S1 = '0; VI1 = 0;
    I2 = '0; S2 = '0; VI2 = 0;
    I3 = '0; S3 = '0; VI3 = 0;

    // reset state
    #1 RST_N = 1'b0;
    #2;
    chk("rst_o0", O0, 8'hA5);  chk("rst_vo0", VO0, 0);
    chk("rst_o1", O1, 8'h3C);  chk("rst_vo1", VO1, 0);
    chk("rst_o2", O2, 4'h9);   chk("rst_vo2", VO2, 0);
    chk("rst_o3", O3, 8'h00);  chk("rst_vo3", VO3, 0);
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // single transactions from the vector table
    for (int n = 0; n < 7; n++) begin
      I0 = tbl[n].d; S0 = tbl[n].s; VI0 = 1'b1;
      tick();
      VI0 = 1'b0;
      I0 = {$urandom, $urandom};
      S0 = 3'($urandom_range(0, 7));
      chk("tbl_early0", VO0, 0);
      tick();
      chk("tbl_early1", VO0, 0);
      tick();
      chk("tbl_vo", VO0, 1);
      chk("tbl_o", O0, tbl[n].e);
      tick();
      chk("tbl_vo_off", VO0, 0);
    end

    // select sweep, back-to-back valids
    I0 = BUS10;
    for (int t = 1; t <= 12; t++) begin
      if (t <= 8) begin
        S0 = 3'(t - 1); VI0 = 1'b1;
      end else begin
        S0 = 3'd0; VI0 = 1'b0;
      end
      tick();
      chk("sweep_vo", VO0, (t >= 3 && t <= 10));
      if (t >= 3 && t <= 10) chk("sweep_o", O0, 64'h10 + t - 3);
    end

    // clock-enable stall mid-pipe
    I0 = BUS10; S0 = 3'd2; VI0 = 0;
    repeat (4) tick();
    S0 = 3'd6; VI0 = 1'b1;
    tick();
    S0 = 3'd1; VI0 = 1'b0;
    tick();
    chk("stall_pre_o", O0, 8'h12);
    chk("stall_pre_vo", VO0, 0);
    CE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      S0 = 3'($urandom_range(0, 7)); VI0 = 1'b1;
      tick();
      chk("stall_o", O0, 8'h12);
      chk("stall_vo", VO0, 0);
    end
    S0 = 3'd1; VI0 = 1'b0; CE = 1'b1;
    tick();
    chk("resume_o", O0, 8'h16);
    chk("resume_vo", VO0, 1);
    CE = 1'b0;
    tick();
    chk("frozen_vo", VO0, 1);
    chk("frozen_o", O0, 8'h16);
    CE = 1'b1;
    tick();
    chk("after_o", O0, 8'h11);
    chk("after_vo", VO0, 0);

    // async reset with transactions in flight
    S0 = 3'd2; VI0 = 0;
    repeat (4) tick();
    S0 = 3'd3; VI0 = 1'b1; tick();
    S0 = 3'd4; tick();
    S0 = 3'd5; tick();
    VI0 = 1'b0;
    chk("prerst_o", O0, 8'h13);
    chk("prerst_vo", VO0, 1);
    RST_N = 1'b0;
    #2;
    chk("arst_o", O0, 8'hA5);
    chk("arst_vo", VO0, 0);
    tick();
    chk("rst_hold_o", O0, 8'hA5);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_vo", VO0, 0);
    end
    S0 = 3'd7; VI0 = 1'b1;
    tick();
    VI0 = 1'b0;
    tick();
    chk("post_rst_vo1", VO0, 0);
    tick();
    chk("post_rst_new_vo", VO0, 1);
    chk("post_rst_new_o", O0, 8'h17);

    // random traffic on all configurations
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int c = 0; c < 400; c++) begin
      CE  = ($urandom_range(0, 3) != 0);
      I0  = {$urandom, $urandom};
      S0  = 3'($urandom_range(0, 7));
      VI0 = 1'($urandom_range(0, 1));
      I1  = 16'($urandom);
      S1  = 1'($urandom_range(0, 1));
      VI1 = 1'($urandom_range(0, 1));
      for (int w = 0; w < 8; w++) I2[w*32 +: 32] = $urandom;
      S2  = 6'($urandom_range(0, 63));
      VI2 = 1'($urandom_range(0, 1));
      I3  = {$urandom, $urandom};
      S3  = 3'($urandom_range(0, 7));
      VI3 = 1'($urandom_range(0, 1));
      tick();
      if (CE) begin
        q0.push_back('{VI0, I0[S0*8 +: 8]});
        q1.push_back('{VI1, I1[S1*8 +: 8]});
        q2.push_back('{VI2, {4'h0, I2[S2*4 +: 4]}});
        q3.push_back('{VI3, I3[S3*8 +: 8]});
        if (q0.size() > 8) q0.delete(0);
        if (q1.size() > 8) q1.delete(0);
        if (q2.size() > 8) q2.delete(0);
        if (q3.size() > 8) q3.delete(0);
      end
      e = (q0.size() >= 3) ? q0[q0.size()-3] : '{1'b0, 8'hA5};
      chk("rnd_vo0", VO0, e.v); chk("rnd_o0", O0, e.o);
      e = (q1.size() >= 1) ? q1[q1.size()-1] : '{1'b0, 8'h3C};
      chk("rnd_vo1", VO1, e.v); chk("rnd_o1", O1, e.o);
      e = (q2.size() >= 1) ? q2[q2.size()-1] : '{1'b0, 8'h09};
      chk("rnd_vo2", VO2, e.v); chk("rnd_o2", O2, e.o);
      e = (q3.size() >= 2) ? q3[q3.size()-2] : '{1'b0, 8'h00};
      chk("rnd_vo3", VO3, e.v); chk("rnd_o3", O3, e.o);
`ifdef MUXF_TREE_LO_EN
      chk("lo0", LO0, O0); chk("lo1", LO1, O1);
      chk("lo2", LO2, O2); chk("lo3", LO3, O3);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
